// File: rtl/vjtag_bus_engine_if.sv
// vjtag_bus_engine_if
// Groups the three handshake streams and the system-bus port of the VJTAG
// command executor.
//   cmd_*  : command stream (op, start byte address, beats-1)
//   wr_*   : write-data beat stream
//   rd_*   : read-response FIFO output (first-word-fall-through)
//   req_*  : system bus request (registered in the engine)
//   rsp_*  : system bus read response
// Modports:
//   slave  : the engine
//   master : the host and bus side that drives the engine
interface vjtag_bus_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output req_valid, req_addr, req_write, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  req_valid, req_addr, req_write, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/vjtag_bus_engine.sv
// vjtag_bus_engine
// System-clock command executor for the VJTAG host. Executes single and burst
// bus reads/writes with byte-address auto-increment, buffers read responses in
// a small FIFO, times out missing read responses (sticky err_timeout), and
// drives a system reset output on command.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   bus         : vjtag_bus_engine_if.slave (cmd / wr / rd / req / rsp)
//   rst_n_out   : system reset output, active low
//   busy        : engine not idle
//   err_timeout : sticky read-response timeout flag
module vjtag_bus_engine #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 8,
  parameter int RD_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  vjtag_bus_engine_if.slave        bus,
  output logic                     rst_n_out,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam logic [7:0] OP_READ    = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_BREAD   = 8'h03;
  localparam logic [7:0] OP_BWRITE  = 8'h04;
  localparam logic [7:0] OP_CLR_ERR = 8'hFD;
  localparam logic [7:0] OP_RST_A   = 8'hFE;
  localparam logic [7:0] OP_RST_D   = 8'hFF;

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(RD_FIFO_DEPTH);
  localparam logic [TMO_W-1:0]      TMO_ZERO   = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]      TMO_ONE    = TMO_W'(1);
  localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_RDREQ = 3'd2,
    ST_REQ   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t                  state_r;
  logic                    req_valid_r;
  logic                    req_write_r;
  logic [ADDR_WIDTH-1:0]   req_addr_r;
  logic [DATA_WIDTH-1:0]   req_wdata_r;
  logic [LEN_WIDTH-1:0]    beats_left_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic                    rst_n_out_r;
  logic                    err_timeout_r;

  logic [DATA_WIDTH-1:0]   fifo_mem_r [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;

  logic                    push_s;
  logic [DATA_WIDTH-1:0]   push_data_s;
  logic                    timeout_s;
  logic                    pop_s;
  logic                    fifo_space_s;

  // Only one read is ever outstanding, so a free slot now guarantees room
  // for its response when it arrives.
  assign fifo_space_s = (count_r < CNT_FULL);
  assign pop_s        = (count_r != CNT_ZERO) && bus.rd_ready;

  // Response capture: real data on rsp_valid, or a zero word on timeout.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = DATA_ZERO;
    timeout_s   = 1'b0;
    if (state_r == ST_RESP) begin
      if (bus.rsp_valid) begin
        push_s      = 1'b1;
        push_data_s = bus.rsp_rdata;
      end else if (tmo_cnt_r == TMO_LAST) begin
        push_s      = 1'b1;
        push_data_s = DATA_ZERO;
        timeout_s   = 1'b1;
      end else begin
        push_s      = 1'b0;
        push_data_s = DATA_ZERO;
      end
    end else begin
      push_s      = 1'b0;
      push_data_s = DATA_ZERO;
    end
  end

  // Command FSM with registered bus request, reset output and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      req_valid_r   <= 1'b0;
      req_write_r   <= 1'b0;
      req_addr_r    <= ADDR_ZERO;
      req_wdata_r   <= DATA_ZERO;
      beats_left_r  <= LEN_ZERO;
      tmo_cnt_r     <= TMO_ZERO;
      rst_n_out_r   <= 1'b1;
      err_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_READ, OP_BREAD: begin
                req_addr_r   <= bus.cmd_addr;
                req_write_r  <= 1'b0;
                beats_left_r <= (bus.cmd_op == OP_BREAD) ? bus.cmd_len : LEN_ZERO;
                // Issue straight away when there is room, so a single read
                // shows req_valid the cycle after acceptance.
                if (fifo_space_s) begin
                  req_valid_r <= 1'b1;
                  state_r     <= ST_REQ;
                end else begin
                  state_r     <= ST_RDREQ;
                end
              end
              OP_WRITE, OP_BWRITE: begin
                req_addr_r   <= bus.cmd_addr;
                req_write_r  <= 1'b1;
                beats_left_r <= (bus.cmd_op == OP_BWRITE) ? bus.cmd_len : LEN_ZERO;
                state_r      <= ST_WDATA;
              end
              OP_CLR_ERR: err_timeout_r <= 1'b0;
              OP_RST_A:   rst_n_out_r   <= 1'b0;
              OP_RST_D:   rst_n_out_r   <= 1'b1;
              default:    state_r       <= ST_IDLE;
            endcase
          end
        end
        ST_WDATA: begin
          if (bus.wr_valid) begin
            req_wdata_r <= bus.wr_data;
            req_write_r <= 1'b1;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end
        end
        ST_RDREQ: begin
          if (fifo_space_s) begin
            req_write_r <= 1'b0;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.req_ready) begin
            req_valid_r <= 1'b0;
            if (req_write_r) begin
              if (beats_left_r != LEN_ZERO) begin
                beats_left_r <= beats_left_r - LEN_ONE;
                req_addr_r   <= req_addr_r + BEAT_BYTES;
                state_r      <= ST_WDATA;
              end else begin
                state_r      <= ST_IDLE;
              end
            end else begin
              tmo_cnt_r <= TMO_ZERO;
              state_r   <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (push_s) begin
            if (timeout_s) begin
              err_timeout_r <= 1'b1;
            end
            if (beats_left_r != LEN_ZERO) begin
              beats_left_r <= beats_left_r - LEN_ONE;
              req_addr_r   <= req_addr_r + BEAT_BYTES;
              state_r      <= ST_RDREQ;
            end else begin
              state_r      <= ST_IDLE;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        default: begin
          req_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-response FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates rd_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  assign bus.cmd_ready = (state_r == ST_IDLE);
  assign bus.wr_ready  = (state_r == ST_WDATA);
  assign bus.rd_valid  = (count_r != CNT_ZERO);
  assign bus.rd_data   = fifo_mem_r[rd_ptr_r];
  assign bus.req_valid = req_valid_r;
  assign bus.req_addr  = req_addr_r;
  assign bus.req_write = req_write_r;
  assign bus.req_wdata = req_wdata_r;
  assign busy          = (state_r != ST_IDLE);
  assign rst_n_out     = rst_n_out_r;
  assign err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_vjtag_bus_engine.sv
// tb_vjtag_bus_engine
// Self-checking bench for vjtag_bus_engine: reset state, a table of directed
// commands, hand-written multi-cycle corner cases (FIFO back-pressure, held
// request, response timeout, reset commands, address wrap, reset mid-burst)
// and randomized commands checked against a transaction-level model.
module tb_vjtag_bus_engine;
  localparam int AW = 16, DW = 16, LW = 8, DEPTH = 4, TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst_n_out, busy, err_timeout;

  vjtag_bus_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  vjtag_bus_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .RD_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rst_n_out(rst_n_out), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [15:0] wd0;
    int          exp_n;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    logic        exp_rst_n;
  } vec_t;

  int n_cmp = 0;
  int n_mis = 0;
  int ready_pct = 100, pop_pct = 100, wr_pct = 100, rsp_maxd = 0;
  bit rsp_never = 1'b0, rsp_force = 1'b0;
  int rsp_wait = -1;
  logic [15:0] rsp_next = 16'h0;
  int reads_out = 0;
  bit ovf = 1'b0;
  bit acc;
  logic [15:0] wr_q[$];
  req_t req_seen[$], exp_req[$];
  logic [15:0] rd_seen[$], exp_rd[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive host/bus inputs, log the handshakes the next posedge will
  // take, then move to the following negedge.
  task automatic tick();
    logic [15:0] dummy;
    bus.req_ready = ($urandom_range(0, 99) < ready_pct);
    bus.rd_ready  = ($urandom_range(0, 99) < pop_pct);
    if (wr_q.size() > 0 && $urandom_range(0, 99) < wr_pct) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wr_q[0];
    end else begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = 16'($urandom);
    end
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 16'($urandom);
    if (rsp_force) begin
      bus.rsp_valid = 1'b1;
    end else if (rsp_wait == 0) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = rsp_next;
      exp_rd.push_back(rsp_next);
      rsp_next  = rsp_next + 16'd1;
      rsp_wait  = -1;
    end else if (rsp_wait > 0) begin
      rsp_wait--;
    end
    acc = bus.cmd_valid && bus.cmd_ready;
    if (bus.req_valid && bus.req_ready) begin
      req_seen.push_back({bus.req_addr, bus.req_write, bus.req_wdata});
      if (!bus.req_write) begin
        reads_out++;
        if (!rsp_never) rsp_wait = $urandom_range(0, rsp_maxd);
      end
    end
    if (bus.wr_valid && bus.wr_ready) dummy = wr_q.pop_front();
    if (bus.rd_valid && bus.rd_ready) begin
      rd_seen.push_back(bus.rd_data);
      reads_out--;
    end
    if (reads_out > DEPTH) ovf = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] len);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    acc = 1'b0;
    while (!acc && t < 2000) begin
      tick();
      t++;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 8'($urandom);
    check("cmd_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 3000) begin
      tick();
      t++;
    end
    check("idle_in_time", 64'(busy), 64'd0);
  endtask

  task automatic drain();
    int t = 0;
    pop_pct = 100;
    while (bus.rd_valid && t < 100) begin
      tick();
      t++;
    end
    check("fifo_drained", 64'(bus.rd_valid), 64'd0);
  endtask

  // Transaction-level model: a command expands to beats at addr + 2k (16-bit
  // wrap); write beats carry the write stream in order, read beats return the
  // responses in order.
  task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] len,
                         input logic [15:0] wd0, output int n_seen,
                         output logic [15:0] first, output logic [15:0] last);
    int beats;
    bit wr;
    logic [15:0] d;
    logic [32:0] mask;
    case (op)
      8'h01:   begin beats = 1;          wr = 1'b0; end
      8'h02:   begin beats = 1;          wr = 1'b1; end
      8'h03:   begin beats = int'(len) + 1; wr = 1'b0; end
      8'h04:   begin beats = int'(len) + 1; wr = 1'b1; end
      default: begin beats = 0;          wr = 1'b0; end
    endcase
    req_seen.delete(); rd_seen.delete(); exp_rd.delete(); exp_req.delete();
    for (int k = 0; k < beats; k++) begin
      d = (k == 0) ? wd0 : 16'($urandom);
      if (wr) wr_q.push_back(d);
      exp_req.push_back({16'(int'(addr) + 2 * k), wr, wr ? d : 16'h0000});
    end
    send_cmd(op, addr, len);
    wait_idle();
    drain();
    n_seen = req_seen.size();
    check("req_count", 64'(n_seen), 64'(beats));
    mask = wr ? 33'h1_FFFF_FFFF : 33'h1_FFFF_0000;
    for (int k = 0; k < n_seen && k < beats; k++)
      check("req_beat", 64'(req_seen[k] & mask), 64'(exp_req[k] & mask));
    if (!wr) begin
      check("rd_count", 64'(rd_seen.size()), 64'(beats));
      for (int k = 0; k < rd_seen.size() && k < exp_rd.size(); k++)
        check("rd_data", 64'(rd_seen[k]), 64'(exp_rd[k]));
    end
    first = (n_seen > 0) ? req_seen[0].addr : 16'h0000;
    last  = (n_seen > 0) ? req_seen[n_seen-1].addr : 16'h0000;
  endtask

  task automatic reset_bench_state();
    rsp_wait = -1; reads_out = 0; rsp_force = 1'b0; rsp_never = 1'b0;
    wr_q.delete(); exp_rd.delete(); req_seen.delete(); rd_seen.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int n, t;
    logic [15:0] f, l;
    logic [7:0] op;

    vecs[0] = '{8'h02, 16'h0010, 8'd3, 16'hBEEF, 1, 16'h0010, 16'h0010, 1'b1};
    vecs[1] = '{8'h01, 16'h0030, 8'd9, 16'h0000, 1, 16'h0030, 16'h0030, 1'b1};
    vecs[2] = '{8'h04, 16'h1000, 8'd2, 16'h1111, 3, 16'h1000, 16'h1004, 1'b1};
    vecs[3] = '{8'h03, 16'hFFFC, 8'd3, 16'h0000, 4, 16'hFFFC, 16'h0002, 1'b1};
    vecs[4] = '{8'h04, 16'hFFFE, 8'd1, 16'h2222, 2, 16'hFFFE, 16'h0000, 1'b1};
    vecs[5] = '{8'h55, 16'h0000, 8'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1};
    vecs[6] = '{8'hFE, 16'h0000, 8'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{8'hFF, 16'h0000, 8'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 8'h00; bus.cmd_addr = 16'h0; bus.cmd_len = 8'h0;
    bus.wr_valid = 1'b0; bus.wr_data = 16'h0; bus.rd_ready = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_req", {bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata}, 64'h0);
    check("rst_flags", {rst_n_out, err_timeout, busy, bus.rd_valid, bus.cmd_ready}, 64'b10001);
    rst = 1'b0;
    @(negedge clk);

    // Directed command table.
    ready_pct = 70; wr_pct = 80; rsp_maxd = 3; rsp_next = 16'hA000;
    for (int i = 0; i < 8; i++) begin
      pop_pct = 50;
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].wd0, n, f, l);
      check("vec_n", 64'(n), 64'(vecs[i].exp_n));
      check("vec_first", 64'(f), 64'(vecs[i].exp_first));
      check("vec_last", 64'(l), 64'(vecs[i].exp_last));
      check("vec_rst_n", 64'(rst_n_out), 64'(vecs[i].exp_rst_n));
      check("vec_ready", {busy, bus.cmd_ready}, 64'b01);
    end

    // BREAD stalls on a full FIFO and resumes after two pops.
    reset_bench_state();
    pop_pct = 0; ready_pct = 100; rsp_maxd = 0; rsp_next = 16'd1;
    send_cmd(8'h03, 16'h0100, 8'd5);
    repeat (60) tick();
    check("t2_stall_reqs", 64'(req_seen.size()), 64'd4);
    check("t2_stall_valid", {bus.req_valid, busy, bus.rd_valid}, 64'b011);
    pop_pct = 100;
    repeat (2) tick();
    pop_pct = 0;
    repeat (60) tick();
    check("t2_reqs", 64'(req_seen.size()), 64'd6);
    for (int k = 0; k < req_seen.size(); k++)
      check("t2_addr", {req_seen[k].addr, req_seen[k].write}, {16'(16'h0100 + 2 * k), 1'b0});
    wait_idle();
    drain();
    check("t2_rd_count", 64'(rd_seen.size()), 64'd6);
    for (int k = 0; k < rd_seen.size(); k++)
      check("t2_rd_data", 64'(rd_seen[k]), 64'(k + 1));

    // WRITE held by req_ready low for 5 cycles.
    reset_bench_state();
    ready_pct = 0; wr_pct = 100;
    wr_q.push_back(16'h1234);
    send_cmd(8'h02, 16'h0020, 8'd0);
    t = 0;
    while (!bus.req_valid && t < 20) begin tick(); t++; end
    for (int i = 0; i < 6; i++) begin
      check("t3_hold", {bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata},
            {1'b1, 1'b1, 16'h0020, 16'h1234});
      if (i < 5) tick();
    end
    check("t3_no_hs", 64'(req_seen.size()), 64'd0);
    ready_pct = 100;
    tick();
    check("t3_one_hs", 64'(req_seen.size()), 64'd1);
    check("t3_drop", 64'(bus.req_valid), 64'd0);
    wait_idle();

    // READ timeout after 16 RESP cycles, stale response ignored, CLR_ERR.
    reset_bench_state();
    rsp_never = 1'b1; pop_pct = 0; ready_pct = 100;
    send_cmd(8'h01, 16'h0040, 8'd0);
    t = 0;
    while (req_seen.size() == 0 && t < 20) begin tick(); t++; end
    check("t4_req", 64'(req_seen.size()), 64'd1);
    repeat (15) tick();
    check("t4_early", {err_timeout, bus.rd_valid, busy}, 64'b001);
    tick();
    check("t4_timeout", {err_timeout, bus.rd_valid, busy}, 64'b110);
    check("t4_zero", 64'(bus.rd_data), 64'd0);
    rsp_force = 1'b1; tick(); rsp_force = 1'b0; tick();
    pop_pct = 100; tick(); pop_pct = 0;
    check("t4_one_entry", {32'(rd_seen.size()), 1'b0, bus.rd_valid}, {32'd1, 2'b00});
    check("t4_popped", 64'(rd_seen[0]), 64'd0);
    send_cmd(8'hFD, 16'h0000, 8'd0);
    check("t4_clr", 64'(err_timeout), 64'd0);
    rsp_never = 1'b0;

    // Reset-output commands take effect the cycle after acceptance.
    reset_bench_state();
    send_cmd(8'hFE, 16'h0000, 8'd0);
    check("t5_rsta", {rst_n_out, busy}, 64'b00);
    send_cmd(8'hFF, 16'h0000, 8'd0);
    check("t5_rstd", {rst_n_out, busy}, 64'b10);
    check("t5_noreq", 64'(req_seen.size()), 64'd0);

    // Reset asserted in the middle of a burst read.
    reset_bench_state();
    pop_pct = 0; ready_pct = 100; rsp_maxd = 2;
    send_cmd(8'h03, 16'h0200, 8'd7);
    t = 0;
    while (req_seen.size() < 3 && t < 200) begin tick(); t++; end
    check("t6_progress", 64'(req_seen.size() >= 3), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_async", {bus.req_valid, bus.rd_valid, busy, bus.cmd_ready}, 64'b0001);
    reset_bench_state();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) tick();
    check("t6_quiet", {32'(req_seen.size()), busy, bus.rd_valid}, 64'd0);

    // Randomized commands against the model.
    reset_bench_state();
    rsp_next = 16'($urandom);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       op = 8'h01;
        1:       op = 8'h02;
        2:       op = 8'h03;
        3:       op = 8'h04;
        default: op = 8'($urandom_range(5, 252));
      endcase
      ready_pct = $urandom_range(30, 100);
      pop_pct   = $urandom_range(10, 100);
      wr_pct    = $urandom_range(30, 100);
      rsp_maxd  = $urandom_range(0, 6);
      run_cmd(op, 16'($urandom), 8'($urandom_range(0, 9)), 16'($urandom), n, f, l);
    end
    check("rand_no_timeout", 64'(err_timeout), 64'd0);
    check("fifo_bound", 64'(ovf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/vjtag_bus_engine.md
Name: vjtag_bus_engine

Overview:
- System-clock command executor for the VJTAG host. It sits between the synchronized command side (IR/DR captures already moved into the clk domain) and the system bus.
- It generalises the single-beat read/write controller with several additions: burst reads and writes with address auto-increment, a write-data stream, and a buffered read-response FIFO.
- It also adds a response timeout with sticky error status, plus reset-assert and reset-deassert commands.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 16, bus data width; power of 2, >= 8
LEN_WIDTH, 8, burst length field width (beats-1)
RD_FIFO_DEPTH, 4, read response FIFO entries; power of 2, >= 2
TIMEOUT_CYCLES, 255, max cycles waiting for rsp_valid; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  8  opcode
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_len  in  LEN_WIDTH  beats-1 (burst ops only)
wr_valid  in  1  write data beat valid
wr_ready  out  1  write data beat accepted
wr_data  in  DATA_WIDTH  write data
rd_valid  out  1  read FIFO not empty
rd_ready  in  1  pop read FIFO
rd_data  out  DATA_WIDTH  read FIFO head
req_valid  out  1  bus request valid
req_addr  out  ADDR_WIDTH  bus byte address
req_write  out  1  1 write, 0 read
req_wdata  out  DATA_WIDTH  bus write data
req_ready  in  1  bus ready
rsp_valid  in  1  read response valid
rsp_rdata  in  DATA_WIDTH  read response data
rst_n_out  out  1  system reset output, active low
busy  out  1  state != IDLE
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting rst forces all state immediately:
  - state=IDLE; req_valid=0, req_write=0, req_addr=0, req_wdata=0.
  - rst_n_out=1, err_timeout=0, busy=0.
  - FIFO emptied, so rd_valid=0.
  - All counters cleared.
- A reset mid-burst abandons the burst with no further bus activity.
- Opcodes:
  - 0x01 READ: 1 beat; cmd_len ignored.
  - 0x02 WRITE: 1 beat; cmd_len ignored.
  - 0x03 BREAD: cmd_len+1 beats.
  - 0x04 BWRITE: cmd_len+1 beats.
  - 0xFD CLR_ERR: clears err_timeout.
  - 0xFE RST_A: rst_n_out<=0.
  - 0xFF RST_D: rst_n_out<=1.
  - Any other opcode: accepted and dropped.
- Non-bus opcodes (0xFD-0xFF) take effect the cycle after acceptance and stay in IDLE.
- cmd_ready = (state==IDLE). All bus outputs are registered.
- Addressing: beat k address = cmd_addr + k*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH (wraps silently).
- States:
  - IDLE: on read-op acceptance at cycle N, go to RDREQ. On write-op acceptance, go to WDATA.
  - WDATA: wr_ready=1. On wr_valid, latch wr_data into req_wdata, set req_valid=1 and req_write=1 next cycle, go to REQ.
  - RDREQ: wait until FIFO free slots >= 1, counting the one outstanding read. Then req_valid=1, req_write=0 next cycle, go to REQ.
    - Single read latency: req_valid high at N+1 when the FIFO has space.
  - REQ: req_valid, req_addr, req_write and req_wdata are held stable until req_ready. On the req_valid&req_ready cycle, req_valid drops next cycle.
    - Write: if more beats remain, go to WDATA; else go to IDLE.
    - Read: go to RESP.
    - REQ never times out.
  - RESP: a counter increments each cycle.
    - On rsp_valid, push rsp_rdata into the FIFO.
    - If no rsp_valid after TIMEOUT_CYCLES cycles, push 0, set err_timeout=1, and ignore later stale rsp_valid.
    - Then go to RDREQ if beats remain, else IDLE.
- rsp_valid outside RESP is ignored.
- FIFO:
  - rd_valid = !empty; rd_data = head, first-word-fall-through.
  - Pop on rd_valid&rd_ready.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by construction; it is an assertion in the bench.
- CLR_ERR and a timeout in the same cycle cannot occur, because CLR_ERR is only accepted in IDLE.

Test Plan:
1. Single WRITE, addr 0x0010, wr_data 0xBEEF, req_ready=1 -> exactly one req: addr 0x0010, write=1, wdata 0xBEEF; busy returns 0; cmd_ready high again.
2. BREAD, addr 0x0100, len=5, rsp returns 1..6, rd_ready=0 -> reqs at 0x100, 0x102, 0x104, 0x106, then req_valid stays 0 with FIFO full (4). Pop two -> reqs 0x108 and 0x10A follow; FIFO outputs 1..6 in order.
3. WRITE with req_ready low for 5 cycles -> req_valid, addr and wdata stable throughout; single handshake on the 6th cycle.
4. READ, TIMEOUT_CYCLES=16, rsp never arrives -> after 16 RESP cycles, FIFO receives 0 and err_timeout=1. Late rsp_valid is ignored. CLR_ERR -> err_timeout=0.
5. RST_A then RST_D -> rst_n_out goes 0 the cycle after the first accept and 1 after the second; no req_valid.
6. BWRITE, addr 0xFFFE, len=1 -> addrs 0xFFFE then 0x0000. A separate BREAD with rst asserted mid-burst -> req_valid=0 immediately, rd_valid=0, state IDLE.
